instr_prefetch_buffer: RTL and testbench

- Instruction fetch front end that sits directly upstream of the operand-fetch/decode stage.
- Generates sequential fetch addresses and issues pipelined requests to instruction memory (up to MAX_OUTST in flight).
- Buffers returned words with their PCs in a DEPTH-entry FIFO and presents them to decode with a valid/ready handshake.
- On an execute-stage branch redirect it flushes the FIFO and discards stale in-flight responses.

---
 rtl/instr_prefetch_buffer.sv | 137 +++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch front end: sequential fetch with pipelined memory requests,
// a PC-tagged FIFO towards decode, and branch flush that discards stale responses.
module instr_prefetch_buffer #(
   parameter int               XLEN      = 32,
   parameter int               DEPTH     = 4,
   parameter int               MAX_OUTST = 2,
   parameter logic [XLEN-1:0]  RESET_PC  = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_halt,
   input  logic             i_branch_en,
   input  logic [XLEN-1:0]  i_branch_addr,
   output logic             o_imem_req,
   output logic [XLEN-1:0]  o_imem_addr,
   input  logic             i_imem_ready,
   input  logic             i_imem_rvalid,
   input  logic [XLEN-1:0]  i_imem_rdata,
   output logic             o_instr_valid,
   output logic [XLEN-1:0]  o_instr,
   output logic [XLEN-1:0]  o_instr_pc,
   input  logic             i_instr_ready,
   output logic             o_err
);

   localparam int              AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              CW          = AW + 1;
   localparam logic [CW:0]     DEPTH_W     = (CW+1)'(DEPTH);
   localparam logic [CW-1:0]   MAX_OUTST_W = CW'(MAX_OUTST);
   localparam logic [XLEN-1:0] PC_STEP     = XLEN'(4);
   localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);

   logic [XLEN-1:0] fpc, fpc_nxt;
   logic [XLEN-1:0] rpc, rpc_nxt;
   logic [CW-1:0]   count, count_nxt;
   logic [CW-1:0]   outst, outst_nxt;
   logic [CW-1:0]   drop, drop_nxt;
   logic [AW-1:0]   wr_ptr, wr_ptr_nxt;
   logic [AW-1:0]   rd_ptr, rd_ptr_nxt;
   logic            err_nxt;

   logic [XLEN-1:0] mem_instr [DEPTH];
   logic [XLEN-1:0] mem_pc    [DEPTH];

   logic [XLEN-1:0] target;
   logic            accept;
   logic            rsp;
   logic            spurious;
   logic            push;
   logic            pop;
   logic            instr_valid;

   assign target      = i_branch_addr & ALIGN_MASK;
   assign instr_valid = (count != '0);

   // Reserving FIFO space for every in-flight word makes overflow impossible.
   assign o_imem_req  = !i_rst && !i_halt && !i_branch_en
                        && (({1'b0, count} + {1'b0, outst}) < DEPTH_W)
                        && (outst < MAX_OUTST_W);
   assign o_imem_addr = fpc;

   assign accept   = o_imem_req && i_imem_ready;
   assign rsp      = i_imem_rvalid && (outst != '0);
   assign spurious = i_imem_rvalid && (outst == '0);
   assign push     = rsp && (drop == '0) && !i_branch_en && !i_rst;
   assign pop      = instr_valid && i_instr_ready && !i_branch_en;

   assign o_instr_valid = instr_valid;
   assign o_instr       = instr_valid ? mem_instr[rd_ptr] : '0;
   assign o_instr_pc    = instr_valid ? mem_pc[rd_ptr]    : '0;

   always_comb begin
      fpc_nxt    = fpc;
      rpc_nxt    = rpc;
      count_nxt  = count;
      drop_nxt   = drop;
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      err_nxt    = o_err || spurious;
      outst_nxt  = outst + CW'(accept) - CW'(rsp);

      if (i_branch_en) begin
         // Everything still in flight after this cycle belongs to the old path.
         fpc_nxt    = target;
         rpc_nxt    = target;
         count_nxt  = '0;
         drop_nxt   = outst - CW'(rsp);
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
      end else begin
         if (accept) begin
            fpc_nxt = fpc + PC_STEP;
         end
         if (rsp && (drop != '0)) begin
            drop_nxt = drop - CW'(1);
         end
         if (push) begin
            rpc_nxt    = rpc + PC_STEP;
            wr_ptr_nxt = wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
         end
         count_nxt = count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fpc    <= RESET_PC;
         rpc    <= RESET_PC;
         count  <= '0;
         outst  <= '0;
         drop   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         o_err  <= 1'b0;
      end else begin
         fpc    <= fpc_nxt;
         rpc    <= rpc_nxt;
         count  <= count_nxt;
         outst  <= outst_nxt;
         drop   <= drop_nxt;
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         o_err  <= err_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= i_imem_rdata;
         mem_pc[wr_ptr]    <= rpc;
      end
   end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: in-order variable-latency memory model plus a
// queue-based model of what decode must see after each reset or redirect.
module tb_instr_prefetch_buffer;

   localparam int          DEPTH     = 4;
   localparam int          MAX_OUTST = 2;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_halt = 1'b0;
   logic        i_branch_en = 1'b0;
   logic [31:0] i_branch_addr = '0;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ready = 1'b0;
   logic        i_imem_rvalid = 1'b0;
   logic [31:0] i_imem_rdata = '0;
   logic        o_instr_valid;
   logic [31:0] o_instr;
   logic [31:0] o_instr_pc;
   logic        i_instr_ready = 1'b0;
   logic        o_err;

   always #5 i_clk = ~i_clk;

   instr_prefetch_buffer #(
      .XLEN(32), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_halt(i_halt),
      .i_branch_en(i_branch_en), .i_branch_addr(i_branch_addr),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_ready(i_imem_ready), .i_imem_rvalid(i_imem_rvalid),
      .i_imem_rdata(i_imem_rdata), .o_instr_valid(o_instr_valid),
      .o_instr(o_instr), .o_instr_pc(o_instr_pc),
      .i_instr_ready(i_instr_ready), .o_err(o_err)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          live;
   } flight_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   flight_t     inflight[$];
   logic [31:0] fifo_pc[$];
   logic [31:0] exp_fpc;
   bit          exp_err;

   // DUT values captured by the most recent step
   logic        smp_req, smp_valid, smp_err;
   logic [31:0] smp_addr, smp_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic model_clear();
      inflight.delete();
      fifo_pc.delete();
      exp_fpc = RESET_PC;
      exp_err = 1'b0;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge i_clk);
         i_rst = 1'b1; i_halt = 1'b0; i_branch_en = 1'b0;
         i_imem_ready = 1'b0; i_imem_rvalid = 1'b0; i_instr_ready = 1'b0;
         #1;
         checks++;
         if (o_imem_req !== 1'b0) begin
            errors++; $display("FAIL reset_req got=%b exp=0", o_imem_req);
         end
         if (i >= 1) begin
            checks++;
            if (o_instr_valid !== 1'b0 || o_instr !== 32'h0 || o_instr_pc !== 32'h0 || o_err !== 1'b0) begin
               errors++;
               $display("FAIL reset_outputs got valid=%b instr=%h pc=%h err=%b exp 0/0/0/0",
                        o_instr_valid, o_instr, o_instr_pc, o_err);
            end
         end
         cyc++;
      end
      model_clear();
   endtask

   task automatic step(input bit halt, input bit br, input logic [31:0] baddr,
                       input bit irdy, input bit drdy, input int lat, input bit spur);
      bit      exp_req, rv, did_pop;
      flight_t f;
      int      due;
      @(negedge i_clk);
      i_rst = 1'b0; i_halt = halt; i_branch_en = br; i_branch_addr = baddr;
      i_imem_ready = irdy; i_instr_ready = drdy;
      rv = (inflight.size() > 0) && (inflight[0].due <= cyc);
      i_imem_rvalid = rv || (spur && inflight.size() == 0);
      i_imem_rdata  = rv ? mem_word(inflight[0].addr) : $urandom();
      #1;
      smp_req = o_imem_req; smp_addr = o_imem_addr; smp_valid = o_instr_valid;
      smp_pc = o_instr_pc; smp_err = o_err;

      exp_req = !halt && !br && (fifo_pc.size() + inflight.size() < DEPTH)
                && (inflight.size() < MAX_OUTST);
      checks++;
      if (o_imem_req !== exp_req) begin
         errors++; $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, o_imem_req, exp_req);
      end
      if (exp_req) begin
         checks++;
         if (o_imem_addr !== exp_fpc) begin
            errors++; $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, o_imem_addr, exp_fpc);
         end
      end
      checks++;
      if (o_instr_valid !== (fifo_pc.size() != 0)) begin
         errors++; $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, o_instr_valid, fifo_pc.size() != 0);
      end
      if (fifo_pc.size() != 0) begin
         checks++;
         if (o_instr_pc !== fifo_pc[0] || o_instr !== mem_word(fifo_pc[0])) begin
            errors++;
            $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                     cyc, o_instr_pc, o_instr, fifo_pc[0], mem_word(fifo_pc[0]));
         end
      end
      checks++;
      if (o_err !== exp_err) begin
         errors++; $display("FAIL err cyc=%0d got=%b exp=%b", cyc, o_err, exp_err);
      end

      if (spur && inflight.size() == 0) exp_err = 1'b1;
      did_pop = (fifo_pc.size() != 0) && drdy && !br;
      if (did_pop) void'(fifo_pc.pop_front());
      if (rv) begin
         f = inflight.pop_front();
         if (f.live && !br) fifo_pc.push_back(f.addr);
      end
      if (br) begin
         fifo_pc.delete();
         foreach (inflight[k]) inflight[k].live = 1'b0;
         exp_fpc = {baddr[31:2], 2'b00};
      end
      if (exp_req && irdy) begin
         due = cyc + lat;
         if (inflight.size() > 0 && due <= inflight[inflight.size()-1].due)
            due = inflight[inflight.size()-1].due + 1;
         inflight.push_back('{addr: exp_fpc, due: due, live: 1'b1});
         exp_fpc = exp_fpc + 32'd4;
      end
      cyc++;
   endtask

   task automatic test_reset();
      do_reset(3);
   endtask

   task automatic test_stream();
      int first_valid = -1;
      int valid_cnt = 0;
      int pc_bad = 0;
      do_reset(2);
      for (int s = 0; s < 20; s++) begin
         step(0, 0, 0, 1, 1, 1, 0);
         if (s == 0) begin
            checks++;
            if (smp_req !== 1'b1 || smp_addr !== 32'h0) begin
               errors++; $display("FAIL stream_first_req got req=%b addr=%h exp 1/00000000", smp_req, smp_addr);
            end
         end
         if (smp_valid === 1'b1) begin
            if (first_valid < 0) first_valid = s;
            valid_cnt++;
            if (smp_pc !== 32'(s - 2) * 32'd4) pc_bad++;
         end
      end
      checks++;
      if (first_valid != 2) begin
         errors++; $display("FAIL stream_latency got=%0d exp=2", first_valid);
      end
      checks++;
      if (valid_cnt != 18 || pc_bad != 0) begin
         errors++; $display("FAIL stream_throughput got valid=%0d badpc=%0d exp 18/0", valid_cnt, pc_bad);
      end
   endtask

   task automatic test_backpressure();
      int          acc_cnt = 0;
      logic [31:0] last_addr = '1;
      logic [31:0] popped[$];
      logic [31:0] resume_addr = '1;
      bit          resumed = 0;
      do_reset(2);
      for (int s = 0; s < 10; s++) begin
         step(0, 0, 0, 1, 0, 1, 0);
         if (smp_req === 1'b1) begin acc_cnt++; last_addr = smp_addr; end
      end
      checks++;
      if (acc_cnt != 4 || last_addr !== 32'hC || o_imem_req !== 1'b0) begin
         errors++;
         $display("FAIL bp_fill got acc=%0d last=%h req=%b exp 4/0000000c/0", acc_cnt, last_addr, o_imem_req);
      end
      for (int s = 0; s < 10; s++) begin
         step(0, 0, 0, 1, 1, 1, 0);
         if (smp_valid === 1'b1) popped.push_back(smp_pc);
         if (smp_req === 1'b1 && !resumed) begin resumed = 1; resume_addr = smp_addr; end
      end
      checks++;
      if (popped.size() < 4 || popped[0] !== 32'h0 || popped[1] !== 32'h4
          || popped[2] !== 32'h8 || popped[3] !== 32'hC) begin
         errors++; $display("FAIL bp_drain got n=%0d first=%h exp 0,4,8,c in order", popped.size(),
                            (popped.size() > 0) ? popped[0] : 32'hX);
      end
      checks++;
      if (resume_addr !== 32'h10) begin
         errors++; $display("FAIL bp_resume got=%h exp=00000010", resume_addr);
      end
   endtask

   task automatic test_flush();
      bit found = 0;
      bit saw_first = 0;
      int stale = 0;
      do_reset(2);
      for (int s = 0; s < 20 && !found; s++) begin
         step(0, 0, 0, 1, 1, 2, 0);
         if (smp_req === 1'b1 && smp_addr === 32'hC) found = 1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL flush_setup got=timeout exp=request to 0000000c");
      end
      step(0, 1, 32'h103, 1, 1, 2, 0);
      step(0, 0, 0, 1, 1, 2, 0);
      checks++;
      if (smp_req !== 1'b1 || smp_addr !== 32'h100) begin
         errors++; $display("FAIL flush_target got req=%b addr=%h exp 1/00000100", smp_req, smp_addr);
      end
      for (int s = 0; s < 12; s++) begin
         step(0, 0, 0, 1, 1, 2, 0);
         if (smp_valid === 1'b1) begin
            if (!saw_first) begin
               saw_first = 1;
               checks++;
               if (smp_pc !== 32'h100) begin
                  errors++; $display("FAIL flush_first_pc got=%h exp=00000100", smp_pc);
               end
            end
            if (smp_pc === 32'h8 || smp_pc === 32'hC) stale++;
         end
      end
      checks++;
      if (!saw_first || stale != 0) begin
         errors++; $display("FAIL flush_stale got seen=%b stale=%0d exp 1/0", saw_first, stale);
      end
   endtask

   task automatic test_flush_collision();
      logic v_at_flush;
      do_reset(2);
      for (int s = 0; s < 5; s++) step(0, 0, 0, 1, 1, 1, 0);
      step(0, 1, 32'h200, 1, 1, 1, 0);
      v_at_flush = smp_valid;
      step(0, 0, 0, 1, 1, 1, 0);
      checks++;
      if (v_at_flush !== 1'b1 || smp_valid !== 1'b0) begin
         errors++; $display("FAIL collide_clear got before=%b after=%b exp 1/0", v_at_flush, smp_valid);
      end
      step(0, 0, 0, 1, 1, 1, 0);
      step(0, 0, 0, 1, 1, 1, 0);
      checks++;
      if (smp_valid !== 1'b1 || smp_pc !== 32'h200) begin
         errors++; $display("FAIL collide_target got valid=%b pc=%h exp 1/00000200", smp_valid, smp_pc);
      end
   endtask

   task automatic test_halt();
      bit any_req = 0;
      bit got_word = 0;
      do_reset(2);
      step(0, 0, 0, 1, 1, 3, 0);
      for (int s = 0; s < 5; s++) begin
         step(1, 0, 0, 1, 1, 3, 0);
         if (smp_req !== 1'b0) any_req = 1;
         if (smp_valid === 1'b1 && smp_pc === 32'h0) got_word = 1;
      end
      checks++;
      if (any_req || !got_word) begin
         errors++; $display("FAIL halt_hold got req_seen=%b word=%b exp 0/1", any_req, got_word);
      end
      step(0, 0, 0, 1, 1, 3, 0);
      checks++;
      if (smp_req !== 1'b1 || smp_addr !== 32'h4) begin
         errors++; $display("FAIL halt_resume got req=%b addr=%h exp 1/00000004", smp_req, smp_addr);
      end
   endtask

   task automatic test_err_wrap();
      do_reset(2);
      step(1, 0, 0, 0, 0, 1, 1);
      step(1, 0, 0, 0, 0, 1, 0);
      checks++;
      if (smp_err !== 1'b1 || smp_valid !== 1'b0) begin
         errors++; $display("FAIL err_set got err=%b valid=%b exp 1/0", smp_err, smp_valid);
      end
      for (int s = 0; s < 3; s++) step(1, 0, 0, 0, 0, 1, 0);
      step(0, 1, 32'hFFFF_FFFE, 1, 1, 1, 0);
      step(0, 0, 0, 1, 1, 1, 0);
      checks++;
      if (smp_req !== 1'b1 || smp_addr !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_top got req=%b addr=%h exp 1/fffffffc", smp_req, smp_addr);
      end
      step(0, 0, 0, 1, 1, 1, 0);
      checks++;
      if (smp_req !== 1'b1 || smp_addr !== 32'h0 || smp_err !== 1'b1) begin
         errors++; $display("FAIL wrap_zero got req=%b addr=%h err=%b exp 1/00000000/1", smp_req, smp_addr, smp_err);
      end
      do_reset(2);
      step(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (smp_err !== 1'b0) begin
         errors++; $display("FAIL err_clear got=%b exp=0", smp_err);
      end
   endtask

   task automatic test_random();
      do_reset(2);
      for (int s = 0; s < 3000; s++) begin
         if ($urandom_range(0, 499) == 0) do_reset(2);
         step($urandom_range(0, 7) == 0,
              $urandom_range(0, 19) == 0,
              $urandom(),
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0,
              int'($urandom_range(1, 4)),
              0);
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_flush_collision();
      test_halt();
      test_err_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
